// File: rtl/disp_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : disp_scan_ctrl
// Brief    : Four-digit multiplexed hex display scanner with frame-aligned
//            value updates and optional leading-zero blanking.
// Revision : 1.0
// ============================================================================
module disp_scan_ctrl #(
  parameter int SCAN_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        load,
  input  logic [15:0] value,
  input  logic        blank_lz,
  output logic [3:0]  digit_bin,
  output logic [3:0]  digit_en,
  output logic        blank,
  output logic        frame_done
);

  localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic [0:0] {IDLE = 1'b0, SCAN = 1'b1} state_t;

  state_t        state, state_nx;
  logic [PW-1:0] pcnt, pcnt_nx;
  logic [1:0]    idx, idx_nx;
  logic [15:0]   pend, pend_nx;
  logic          pend_v, pend_v_nx;
  logic [15:0]   act, act_nx;
  logic [3:0]    digit_bin_nx, digit_en_nx;
  logic          blank_nx, frame_done_nx;

  logic          active, pwrap, fwrap, lz_hit;
  logic [3:0]    nib;

  always_comb begin
    state_nx      = enable ? SCAN : IDLE;
    pcnt_nx       = pcnt;
    idx_nx        = idx;
    pend_nx       = pend;
    pend_v_nx     = pend_v;
    act_nx        = act;

    // Scanning only progresses on cycles that stay in SCAN; a drop aborts.
    active = (state == SCAN) && enable;
    pwrap  = (pcnt == PW'(SCAN_DIV - 1));
    fwrap  = active && pwrap && (idx == 2'd3);

    if (load) begin
      pend_nx   = value;
      pend_v_nx = 1'b1;
    end

    if (!active) begin
      pcnt_nx = '0;
      idx_nx  = 2'd0;
      if ((state == IDLE) && pend_v) begin
        act_nx    = pend;
        pend_v_nx = load;
      end
    end else begin
      pcnt_nx = pwrap ? '0 : pcnt + PW'(1);
      if (pwrap) idx_nx = idx + 2'd1;
      if (fwrap) begin
        // A load landing on the wrap goes straight to act, skipping pend.
        if (load) begin
          act_nx    = value;
          pend_nx   = pend;
          pend_v_nx = 1'b0;
        end else if (pend_v) begin
          act_nx    = pend;
          pend_v_nx = 1'b0;
        end
      end
    end

    nib    = act[{idx, 2'b00} +: 4];
    lz_hit = blank_lz && (idx != 2'd0) && ((act >> {idx, 2'b00}) == 16'd0);

    if (active) begin
      digit_bin_nx  = nib;
      digit_en_nx   = lz_hit ? 4'b0000 : (4'b0001 << idx);
      blank_nx      = lz_hit;
      frame_done_nx = fwrap;
    end else begin
      digit_bin_nx  = 4'd0;
      digit_en_nx   = 4'b0000;
      blank_nx      = 1'b1;
      frame_done_nx = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      pcnt       <= '0;
      idx        <= 2'd0;
      pend       <= 16'd0;
      pend_v     <= 1'b0;
      act        <= 16'd0;
      digit_bin  <= 4'd0;
      digit_en   <= 4'b0000;
      blank      <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nx;
      pcnt       <= pcnt_nx;
      idx        <= idx_nx;
      pend       <= pend_nx;
      pend_v     <= pend_v_nx;
      act        <= act_nx;
      digit_bin  <= digit_bin_nx;
      digit_en   <= digit_en_nx;
      blank      <= blank_nx;
      frame_done <= frame_done_nx;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_disp_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_disp_scan_ctrl
// Brief    : Directed self-checking bench for disp_scan_ctrl at SCAN_DIV=4.
// Revision : 1.0
// ============================================================================
module tb_disp_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst, enable, load, blank_lz;
  logic [15:0] value;
  logic [3:0]  digit_bin, digit_en;
  logic        blank, frame_done;
  int          total = 0;
  int          bad   = 0;

  disp_scan_ctrl #(.SCAN_DIV(4)) dut (
    .clk(clk), .rst(rst), .enable(enable), .load(load), .value(value),
    .blank_lz(blank_lz), .digit_bin(digit_bin), .digit_en(digit_en),
    .blank(blank), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic lz_model(input logic [15:0] v, input int p, input logic lz);
    logic [15:0] s;
    s = v >> (4 * p);
    return lz && (p != 0) && (s == 16'd0);
  endfunction

  function automatic logic [3:0] en_model(input logic [15:0] v, input int p, input logic lz);
    logic [3:0] one;
    one = 4'b0001;
    return lz_model(v, p, lz) ? 4'b0000 : (one << p);
  endfunction

  function automatic logic [3:0] bin_model(input logic [15:0] v, input int p);
    return v[4*p +: 4];
  endfunction

  // Reset, load v while idle, let it reach act, then raise enable for one edge.
  task automatic start_scan(input logic [15:0] v, input logic lz);
    rst = 1'b1; enable = 1'b0; load = 1'b0; value = 16'd0; blank_lz = lz;
    tick();
    rst = 1'b0; load = 1'b1; value = v;
    tick();
    load = 1'b0;
    tick();
    tick();
    enable = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b1; load = 1'b1; value = 16'hFFFF; blank_lz = 1'b1;
    tick();
    total++;
    if ({digit_bin, digit_en, blank, frame_done} !== 10'd0) begin
      bad++;
      $display("FAIL reset_outputs: got bin=%h en=%b blank=%b fd=%b, want all 0",
               digit_bin, digit_en, blank, frame_done);
    end
    rst = 1'b0; enable = 1'b0; load = 1'b0;
    tick();
    total++;
    if (digit_en !== 4'b0000 || blank !== 1'b1 || frame_done !== 1'b0) begin
      bad++;
      $display("FAIL reset_idle: got en=%b blank=%b fd=%b, want en=0000 blank=1 fd=0",
               digit_en, blank, frame_done);
    end
    enable = 1'b1;
    tick();
    tick();
    total++;
    if (digit_en !== 4'b0001 || digit_bin !== 4'h0 || blank !== 1'b0) begin
      bad++;
      $display("FAIL reset_load_discard: got en=%b bin=%h blank=%b, want en=0001 bin=0 blank=0",
               digit_en, digit_bin, blank);
    end
  endtask

  task automatic test_basic_scan();
    int p;
    logic fd;
    start_scan(16'h1234, 1'b0);
    total++;
    if (digit_en !== 4'b0000 || blank !== 1'b1) begin
      bad++;
      $display("FAIL basic_enable_edge: got en=%b blank=%b, want en=0000 blank=1", digit_en, blank);
    end
    for (int n = 1; n <= 32; n++) begin
      tick();
      p  = ((n - 1) / 4) % 4;
      fd = (n % 16 == 0);
      total++;
      if (digit_en !== en_model(16'h1234, p, 1'b0) || digit_bin !== bin_model(16'h1234, p) ||
          blank !== 1'b0 || frame_done !== fd) begin
        bad++;
        $display("FAIL basic n=%0d: got en=%b bin=%h blank=%b fd=%b, want en=%b bin=%h blank=0 fd=%b",
                 n, digit_en, digit_bin, blank, frame_done,
                 en_model(16'h1234, p, 1'b0), bin_model(16'h1234, p), fd);
      end
    end
  endtask

  task automatic test_frame_update();
    int p;
    logic fd;
    logic [15:0] v;
    start_scan(16'h1234, 1'b0);
    for (int n = 1; n <= 48; n++) begin
      load  = (n == 6) || (n == 32);
      value = (n == 6) ? 16'hABCD : 16'h5678;
      tick();
      load = 1'b0;
      p  = ((n - 1) / 4) % 4;
      fd = (n % 16 == 0);
      v  = (n <= 16) ? 16'h1234 : ((n <= 32) ? 16'hABCD : 16'h5678);
      total++;
      if (digit_en !== en_model(v, p, 1'b0) || digit_bin !== bin_model(v, p) || frame_done !== fd) begin
        bad++;
        $display("FAIL frame_update n=%0d: got en=%b bin=%h fd=%b, want en=%b bin=%h fd=%b",
                 n, digit_en, digit_bin, frame_done, en_model(v, p, 1'b0), bin_model(v, p), fd);
      end
    end
  endtask

  task automatic test_lz_blank();
    int p;
    logic fd, lz;
    logic [15:0] v;
    start_scan(16'h0050, 1'b1);
    for (int n = 1; n <= 36; n++) begin
      load     = (n == 2);
      value    = 16'h0000;
      blank_lz = (n < 30);
      tick();
      load = 1'b0;
      p  = ((n - 1) / 4) % 4;
      fd = (n % 16 == 0);
      lz = (n < 30);
      v  = (n <= 16) ? 16'h0050 : 16'h0000;
      total++;
      if (digit_en !== en_model(v, p, lz) || digit_bin !== bin_model(v, p) ||
          blank !== lz_model(v, p, lz) || frame_done !== fd) begin
        bad++;
        $display("FAIL lz n=%0d: got en=%b bin=%h blank=%b fd=%b, want en=%b bin=%h blank=%b fd=%b",
                 n, digit_en, digit_bin, blank, frame_done,
                 en_model(v, p, lz), bin_model(v, p), lz_model(v, p, lz), fd);
      end
    end
  endtask

  task automatic test_enable_drop();
    int p;
    start_scan(16'h1234, 1'b0);
    for (int n = 1; n <= 9; n++) tick();
    total++;
    if (digit_en !== 4'b0100 || digit_bin !== 4'h2) begin
      bad++;
      $display("FAIL drop_pre: got en=%b bin=%h, want en=0100 bin=2", digit_en, digit_bin);
    end
    enable = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      total++;
      if (digit_en !== 4'b0000 || blank !== 1'b1 || frame_done !== 1'b0) begin
        bad++;
        $display("FAIL drop_idle k=%0d: got en=%b blank=%b fd=%b, want en=0000 blank=1 fd=0",
                 k, digit_en, blank, frame_done);
      end
    end
    enable = 1'b1;
    tick();
    total++;
    if (digit_en !== 4'b0000 || frame_done !== 1'b0) begin
      bad++;
      $display("FAIL reenable_edge: got en=%b fd=%b, want en=0000 fd=0", digit_en, frame_done);
    end
    for (int n = 1; n <= 5; n++) begin
      tick();
      p = (n - 1) / 4;
      total++;
      if (digit_en !== en_model(16'h1234, p, 1'b0) || digit_bin !== bin_model(16'h1234, p) ||
          frame_done !== 1'b0) begin
        bad++;
        $display("FAIL reenable n=%0d: got en=%b bin=%h fd=%b, want en=%b bin=%h fd=0",
                 n, digit_en, digit_bin, frame_done, en_model(16'h1234, p, 1'b0), bin_model(16'h1234, p));
      end
    end
  endtask

  task automatic test_reset_mid();
    int p;
    start_scan(16'h1234, 1'b0);
    for (int n = 1; n <= 13; n++) tick();
    rst = 1'b1; load = 1'b1; value = 16'hFFFF;
    tick();
    total++;
    if ({digit_bin, digit_en, blank, frame_done} !== 10'd0) begin
      bad++;
      $display("FAIL reset_mid: got bin=%h en=%b blank=%b fd=%b, want all 0",
               digit_bin, digit_en, blank, frame_done);
    end
    rst = 1'b0; load = 1'b0;
    tick();
    total++;
    if (digit_en !== 4'b0000 || blank !== 1'b1 || frame_done !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_idle: got en=%b blank=%b fd=%b, want en=0000 blank=1 fd=0",
               digit_en, blank, frame_done);
    end
    for (int n = 1; n <= 16; n++) begin
      tick();
      p = ((n - 1) / 4) % 4;
      total++;
      if (digit_en !== en_model(16'h0000, p, 1'b0) || digit_bin !== 4'h0 ||
          frame_done !== (n == 16)) begin
        bad++;
        $display("FAIL reset_mid_frame n=%0d: got en=%b bin=%h fd=%b, want en=%b bin=0 fd=%b",
                 n, digit_en, digit_bin, frame_done, en_model(16'h0000, p, 1'b0), (n == 16));
      end
    end
  endtask

  task automatic test_multi_load();
    int p;
    logic [15:0] v;
    start_scan(16'h1234, 1'b0);
    for (int n = 1; n <= 32; n++) begin
      load  = (n >= 3) && (n <= 5);
      value = (n == 3) ? 16'h1111 : ((n == 4) ? 16'h2222 : 16'h3333);
      tick();
      load = 1'b0;
      p = ((n - 1) / 4) % 4;
      v = (n <= 16) ? 16'h1234 : 16'h3333;
      total++;
      if (digit_en !== en_model(v, p, 1'b0) || digit_bin !== bin_model(v, p)) begin
        bad++;
        $display("FAIL multi_load n=%0d: got en=%b bin=%h, want en=%b bin=%h",
                 n, digit_en, digit_bin, en_model(v, p, 1'b0), bin_model(v, p));
      end
    end
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; load = 1'b0; value = 16'd0; blank_lz = 1'b0;
    test_reset();
    test_basic_scan();
    test_frame_update();
    test_lz_blank();
    test_enable_drop();
    test_reset_mid();
    test_multi_load();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/disp_scan_ctrl.md
DISP_SCAN_CTRL -- requirements
Module: disp_scan_ctrl

Interface
REQ-001 Parameter SCAN_DIV, default 50000, SHALL be the number of clk cycles each digit is displayed; legal range is 2 or more.
REQ-002 Port clk  input  1  SHALL be the single system clock; all state updates on its rising edge.
REQ-003 Port rst  input  1  SHALL be the reset, synchronous and active-high.
REQ-004 Port enable  input  1  SHALL be the scan enable; low blanks the display and holds the scan at digit 0.
REQ-005 Port load  input  1  SHALL be a single-cycle strobe that captures value.
REQ-006 Port value  input  16  SHALL carry four hex digits; nibble k is digit k, and digit 0 is the least significant.
REQ-007 Port blank_lz  input  1  SHALL enable leading-zero blanking when high.
REQ-008 Port digit_bin  output  4  SHALL carry the nibble of the current digit, to feed the seven-segment decoder.
REQ-009 Port digit_en  output  4  SHALL be the one-hot, active-high digit select; 0000 means all digits are off.
REQ-010 Port blank  output  1  SHALL be high when the current digit is suppressed.
REQ-011 Port frame_done  output  1  SHALL pulse high for one cycle at the end of each 4-digit frame.

Function
REQ-012 The block SHALL hold three registers: pend (16 bits), pend_v (1 bit) and act (16 bits, the value being displayed).
REQ-013 When load=1, the block SHALL write value to pend and set pend_v at that edge; a later load overwrites pend (last wins).
REQ-014 The block SHALL have two states, IDLE and SCAN; enable=1 moves IDLE to SCAN, and enable=0 moves SCAN to IDLE.
REQ-015 In IDLE:
- the prescaler (pcnt) and digit index (idx) SHALL be held at 0;
- pend SHALL be copied to act whenever pend_v=1, and pend_v cleared;
- a load in IDLE SHALL reach act one cycle after it is captured in pend.
REQ-016 In SCAN, pcnt SHALL count 0 to SCAN_DIV-1 and wrap to 0.
REQ-017 When pcnt=SCAN_DIV-1, idx SHALL advance by 1, wrapping from 3 to 0.
REQ-018 At the 3-to-0 wrap, the block SHALL:
- pulse frame_done at the following edge;
- copy pend to act and clear pend_v, if pend_v=1.
REQ-019 A load on the same cycle as the wrap SHALL bypass pend and be committed to act at that edge, with pend_v left clear.
REQ-020 Outputs SHALL be registered and reflect idx and act with a latency of one cycle.
REQ-021 digit_bin SHALL equal act[4*idx+3 : 4*idx]; digit_en SHALL equal 1<<idx unless the digit is blanked.
REQ-022 Leading-zero blanking SHALL apply only when blank_lz=1:
- a digit k>0 is blanked when nibbles k..3 of act are all zero;
- digit 0 is never blanked;
- a blanked digit drives digit_en=0000 and blank=1, and digit_bin still shows the nibble.
REQ-023 In IDLE, and on the first cycle after entering IDLE, the outputs SHALL be digit_en=0000, blank=1, frame_done=0.
REQ-024 Dropping enable mid-frame SHALL abort the frame with no frame_done pulse.
- On re-enable, scanning restarts at digit 0 with pcnt=0.
- The first digit_en=0001 appears one cycle after the enable edge.
REQ-025 blank_lz changes SHALL take effect on the next registered output update, with no frame alignment.

Reset
REQ-026 While rst=1 at an edge, the block SHALL set:
- state IDLE, pcnt=0, idx=0;
- pend=0, pend_v=0, act=0;
- digit_bin=0, digit_en=0000, blank=0, frame_done=0.
REQ-027 rst SHALL override enable and load; a load in the same cycle as rst SHALL be discarded.
REQ-028 A reset mid-frame SHALL abort the scan immediately, with no frame_done pulse.

Verification (SCAN_DIV=4)
REQ-029 Basic scan: rst, then load value=0x1234 with enable=1.
- digit_en SHALL cycle 0001, 0010, 0100, 1000, each for 4 cycles.
- digit_bin SHALL follow as 4, 3, 2, 1.
- frame_done SHALL pulse once every 16 cycles.
REQ-030 Frame-aligned update: during SCAN, load 0xABCD at digit 1.
- The remainder of the frame SHALL still show 0x1234.
- The next frame SHALL show D, C, B, A.
- A load coincident with the wrap SHALL appear in the very next frame.
REQ-031 Leading-zero blanking: value=0x0050 with blank_lz=1.
- Digits 3 and 2 SHALL show digit_en=0000 and blank=1.
- Digits 1 and 0 SHALL be enabled, showing 5 and 0.
- With value=0x0000, only digit 0 SHALL be enabled, showing 0.
REQ-032 Enable drop: deassert enable during digit 2.
- digit_en SHALL be 0000 on the next cycle, with no frame_done.
- After re-enable, 0001 SHALL appear after one cycle and be held for 4 cycles.
REQ-033 Reset mid-operation: assert rst during digit 3 together with load=0xFFFF.
- All outputs SHALL be 0 after the edge.
- act SHALL be 0, so the first frame after enable shows 0000.
REQ-034 Multiple loads: 0x1111, 0x2222 and 0x3333 on consecutive cycles within one frame; the next frame SHALL show only 0x3333.
